// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB machine timer: register offsets, CTRL field
// positions, handshake states and a byte-strobe merge helper.
package apb_timer_pkg;

  localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
  localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
  localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] OFF_CTRL        = 5'h10;
  localparam logic [4:0] OFF_MSIP        = 5'h14;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_IE        = 1;
  localparam int CTRL_PRESC_LSB = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } apb_state_t;

  // Bytes whose strobe is low keep their old contents.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  stb);
    logic [31:0] result;
    for (int i = 0; i < 4; i++) begin
      result[8*i +: 8] = stb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/apb_slave_fsm.sv
// APB slave handshake with one wait state: commits in the first access-phase
// cycle and raises pready for exactly one cycle in the following cycle.
module apb_slave_fsm
  import apb_timer_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic psel,
  input  logic penable,
  input  logic pwrite,
  output logic wr_commit,
  output logic rd_commit,
  output logic pready
);

  apb_state_t state;
  apb_state_t state_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    wr_commit  = 1'b0;
    rd_commit  = 1'b0;
    case (state)
      IDLE: begin
        if (psel && !penable) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (!psel) begin
          state_next = IDLE;
        end else if (penable) begin
          state_next = DONE;
          wr_commit  = pwrite;
          rd_commit  = !pwrite;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign pready = (state == DONE);

endmodule

// File: rtl/apb_timer.sv
// APB machine timer: 64-bit prescaled mtime, 64-bit mtimecmp, level interrupt.
// Defining APB_TIMER_SOFTIRQ_EN adds the MSIP register and soft_interrupt port.
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                  APB_PCLK,
  input  logic                  APB_PRESET,
  input  logic [ADDR_WIDTH-1:0] APB_paddr,
  input  logic [DATA_WIDTH-1:0] APB_pdata,
  output logic [DATA_WIDTH-1:0] APB_prdata,
  input  logic                  APB_psel,
  input  logic                  APB_penable,
  input  logic                  APB_pwrite,
  input  logic [3:0]            APB_pstb,
  output logic                  APB_pready,
  output logic                  APB_perr,
  output logic                  interrupt
`ifdef APB_TIMER_SOFTIRQ_EN
  ,
  output logic                  soft_interrupt
`endif
);

  logic                   wr_commit;
  logic                   rd_commit;
  logic [63:0]            mtime;
  logic [63:0]            mtimecmp;
  logic [31:0]            hi_shadow;
  logic                   en;
  logic                   ie;
  logic [PRESC_WIDTH-1:0] presc;
  logic [PRESC_WIDTH-1:0] presc_cnt;
  logic [4:0]             offset;
  logic                   mapped;
  logic [DATA_WIDTH-1:0]  rdata;
  logic [31:0]            ctrl_word;
  logic [31:0]            ctrl_new;
  logic                   unused_bits;
`ifdef APB_TIMER_SOFTIRQ_EN
  logic                   msip;
`endif

  apb_slave_fsm u_fsm (
    .clk       (APB_PCLK),
    .reset     (APB_PRESET),
    .psel      (APB_psel),
    .penable   (APB_penable),
    .pwrite    (APB_pwrite),
    .wr_commit (wr_commit),
    .rd_commit (rd_commit),
    .pready    (APB_pready)
  );

  assign offset      = {APB_paddr[4:2], 2'b00};
  assign unused_bits = ^{APB_paddr[ADDR_WIDTH-1:5], APB_paddr[1:0], ctrl_new};

  always_comb begin
    ctrl_word = '0;
    ctrl_word[CTRL_EN] = en;
    ctrl_word[CTRL_IE] = ie;
    ctrl_word[CTRL_PRESC_LSB +: PRESC_WIDTH] = presc;
  end

  assign ctrl_new = merge_bytes(ctrl_word, APB_pdata, APB_pstb);

  // MTIME_HI returns the snapshot taken by the last MTIME_LO read.
  always_comb begin
    rdata  = '0;
    mapped = 1'b1;
    case (offset)
      OFF_MTIME_LO:    rdata = mtime[31:0];
      OFF_MTIME_HI:    rdata = hi_shadow;
      OFF_MTIMECMP_LO: rdata = mtimecmp[31:0];
      OFF_MTIMECMP_HI: rdata = mtimecmp[63:32];
      OFF_CTRL:        rdata = ctrl_word;
`ifdef APB_TIMER_SOFTIRQ_EN
      OFF_MSIP:        rdata = {31'b0, msip};
`else
      OFF_MSIP:        mapped = 1'b0;
`endif
      default:         mapped = 1'b0;
    endcase
  end

  always_ff @(posedge APB_PCLK) begin
    if (APB_PRESET) begin
      mtime      <= '0;
      mtimecmp   <= '1;
      hi_shadow  <= '0;
      en         <= 1'b0;
      ie         <= 1'b0;
      presc      <= '0;
      presc_cnt  <= '0;
      interrupt  <= 1'b0;
      APB_prdata <= '0;
      APB_perr   <= 1'b0;
    end else begin
      // A software write to mtime overrides this cycle's increment.
      if (wr_commit && offset == OFF_MTIME_LO) begin
        mtime[31:0] <= merge_bytes(mtime[31:0], APB_pdata, APB_pstb);
        presc_cnt   <= '0;
      end else if (wr_commit && offset == OFF_MTIME_HI) begin
        mtime[63:32] <= merge_bytes(mtime[63:32], APB_pdata, APB_pstb);
        presc_cnt    <= '0;
      end else if (en) begin
        if (presc_cnt == presc) begin
          presc_cnt <= '0;
          mtime     <= mtime + 64'd1;
        end else begin
          presc_cnt <= presc_cnt + PRESC_WIDTH'(1);
        end
      end else begin
        presc_cnt <= '0;
      end

      if (wr_commit && offset == OFF_MTIMECMP_LO) begin
        mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], APB_pdata, APB_pstb);
      end
      if (wr_commit && offset == OFF_MTIMECMP_HI) begin
        mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], APB_pdata, APB_pstb);
      end
      if (wr_commit && offset == OFF_CTRL) begin
        en    <= ctrl_new[CTRL_EN];
        ie    <= ctrl_new[CTRL_IE];
        presc <= ctrl_new[CTRL_PRESC_LSB +: PRESC_WIDTH];
      end

      if (rd_commit && offset == OFF_MTIME_LO) begin
        hi_shadow <= mtime[63:32];
      end

      interrupt  <= ie && (mtime >= mtimecmp);
      APB_prdata <= (rd_commit && mapped) ? rdata : '0;
      APB_perr   <= (wr_commit || rd_commit) && !mapped;
    end
  end

`ifdef APB_TIMER_SOFTIRQ_EN
  always_ff @(posedge APB_PCLK) begin
    if (APB_PRESET) begin
      msip <= 1'b0;
    end else if (wr_commit && offset == OFF_MSIP && APB_pstb[0]) begin
      msip <= APB_pdata[0];
    end
  end

  assign soft_interrupt = msip;
`endif

endmodule
